// File: rtl/csa_pkg.sv
// Shared constants and parameter-legality helpers for the pipelined carry-select adder.
package csa_pkg;

    localparam int CSA_WIDTH = 16;
    localparam int CSA_BLK   = 4;

    function automatic bit csa_legal(input int width, input int blk);
        return (blk >= 1) && (width >= blk) && ((width % blk) == 0);
    endfunction

    // Falls back to one stage on illegal parameters so elaboration reaches the error check.
    function automatic int csa_nstg(input int width, input int blk);
        return csa_legal(width, blk) ? (width / blk) : 1;
    endfunction

endpackage

// File: rtl/csa_block.sv
// One carry-select block: both carry-in hypotheses are rippled in parallel, csel picks one.
module csa_block
    import csa_pkg::*;
#(
    parameter int BLK = CSA_BLK
) (
    input  logic [BLK-1:0] x,
    input  logic [BLK-1:0] y,
    input  logic           csel,
    output logic [BLK-1:0] s,
    output logic           co
);

    logic [BLK:0]   c0;
    logic [BLK:0]   c1;
    logic [BLK-1:0] s0;
    logic [BLK-1:0] s1;

    always_comb begin
        c0[0] = 1'b0;
        c1[0] = 1'b1;
        s0    = '0;
        s1    = '0;
        for (int i = 0; i < BLK; i++) begin
            s0[i]   = x[i] ^ y[i] ^ c0[i];
            c0[i+1] = (x[i] & y[i]) | (c0[i] & (x[i] ^ y[i]));
            s1[i]   = x[i] ^ y[i] ^ c1[i];
            c1[i+1] = (x[i] & y[i]) | (c1[i] & (x[i] ^ y[i]));
        end
    end

    assign s  = csel ? s1 : s0;
    assign co = csel ? c1[BLK] : c0[BLK];

endmodule

// File: rtl/pipelined_csa_adder.sv
// Pipelined carry-select adder: operand capture register followed by one stage per block,
// with a global stall so the whole pipe advances or holds as a unit.
module pipelined_csa_adder
    import csa_pkg::*;
#(
    parameter int WIDTH = CSA_WIDTH,
    parameter int BLK   = CSA_BLK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSTG = csa_nstg(WIDTH, BLK);

    if (!csa_legal(WIDTH, BLK)) begin : g_bad_params
        $error("pipelined_csa_adder: WIDTH must be a positive multiple of BLK (BLK >= 1)");
    end

    // Handshake: a transfer happens on a rising edge where valid && ready on that side.
    // in_ready equals the global advance, so the pipe only moves when the output slot
    // is empty or being drained; bubbles travel like data and are never squeezed out.
    logic adv;

    logic             cap_vld_q;
    logic [WIDTH-1:0] cap_a_q;
    logic [WIDTH-1:0] cap_b_q;
    logic             cap_cin_q;

    logic [NSTG-1:0]  vld_q, vld_d;
    logic [NSTG-1:0]  cy_q, cy_d;
    logic [WIDTH-1:0] sum_q [NSTG];
    logic [WIDTH-1:0] sum_d [NSTG];
    logic [WIDTH-1:0] opa_q [NSTG];
    logic [WIDTH-1:0] opa_d [NSTG];
    logic [WIDTH-1:0] opb_q [NSTG];
    logic [WIDTH-1:0] opb_d [NSTG];
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] opa_in [NSTG];
    logic [WIDTH-1:0] opb_in [NSTG];
    logic [WIDTH-1:0] sum_in [NSTG];
    logic [NSTG-1:0]  csel_in;
    logic [BLK-1:0]   blk_s  [NSTG];
    logic [NSTG-1:0]  blk_co;

    assign adv       = !vld_q[NSTG-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[NSTG-1];
    assign sum       = sum_q[NSTG-1];
    assign cout      = cy_q[NSTG-1];
    assign ovf       = ovf_q;

    // Operands are kept right-aligned: each stage consumes the low BLK bits and
    // passes the rest down shifted, so block k always sits at bits [BLK-1:0].
    always_comb begin
        opa_in[0]  = cap_a_q;
        opb_in[0]  = cap_b_q;
        sum_in[0]  = '0;
        csel_in[0] = cap_cin_q;
        for (int k = 1; k < NSTG; k++) begin
            opa_in[k]  = opa_q[k-1];
            opb_in[k]  = opb_q[k-1];
            sum_in[k]  = sum_q[k-1];
            csel_in[k] = cy_q[k-1];
        end
    end

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        csa_block #(.BLK(BLK)) u_blk (
            .x    (opa_in[k][BLK-1:0]),
            .y    (opb_in[k][BLK-1:0]),
            .csel (csel_in[k]),
            .s    (blk_s[k]),
            .co   (blk_co[k])
        );
    end

    always_comb begin
        vld_d[0] = cap_vld_q;
        for (int k = 1; k < NSTG; k++) begin
            vld_d[k] = vld_q[k-1];
        end
        for (int k = 0; k < NSTG; k++) begin
            opa_d[k] = opa_in[k] >> BLK;
            opb_d[k] = opb_in[k] >> BLK;
            sum_d[k] = sum_in[k] | (WIDTH'(blk_s[k]) << (k * BLK));
        end
        cy_d  = blk_co;
        ovf_d = (opa_in[NSTG-1][BLK-1] == opb_in[NSTG-1][BLK-1]) &&
                (blk_s[NSTG-1][BLK-1] != opa_in[NSTG-1][BLK-1]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_vld_q <= 1'b0;
            cap_a_q   <= '0;
            cap_b_q   <= '0;
            cap_cin_q <= 1'b0;
            vld_q     <= '0;
            cy_q      <= '0;
            ovf_q     <= 1'b0;
            for (int k = 0; k < NSTG; k++) begin
                sum_q[k] <= '0;
                opa_q[k] <= '0;
                opb_q[k] <= '0;
            end
        end else if (adv) begin
            cap_vld_q <= in_valid;
            cap_a_q   <= a;
            cap_b_q   <= b;
            cap_cin_q <= cin;
            vld_q     <= vld_d;
            cy_q      <= cy_d;
            ovf_q     <= ovf_d;
            for (int k = 0; k < NSTG; k++) begin
                sum_q[k] <= sum_d[k];
                opa_q[k] <= opa_d[k];
                opb_q[k] <= opb_d[k];
            end
        end
    end

endmodule

// File: doc/pipelined_csa_adder.md
# pipelined_csa_adder

Parametrised, pipelined carry-select adder: the next generation of the fixed 16-bit combinational carry-select adder. Operand width and block size are generic. Each carry-select block occupies one pipeline stage. A valid/ready handshake on both sides accepts one addition per cycle under back-pressure. It adds a signed-overflow flag and sits between operand registers and a result consumer in the datapath labs.

## Interface
- WIDTH, 16: operand/sum width in bits; must be a multiple of BLK.
- BLK, 4: bits per carry-select block; NSTG = WIDTH/BLK pipeline stages.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand transfer request.
- in_ready  out  1  block can accept operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry in.
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  consumer accepts result this cycle.
- sum  out  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  out  1  unsigned carry out of bit WIDTH-1.
- ovf  out  1  signed overflow: a[MSB]==b[MSB] and sum[MSB]!=a[MSB].

## Operation
- Global advance: adv = !out_valid || out_ready. in_ready = adv (combinational from out_ready and out_valid).
- Input transfer when in_valid && in_ready; a, b and cin are captured into stage 0.
- Stage k, for k = 0..NSTG-1, computes block k (bits k*BLK+BLK-1 : k*BLK) twice, with carry-in 0 and with carry-in 1.
- Stage k selects one of the two results with the carry registered by stage k-1; stage 0 uses the captured cin.
- Each stage registers its selected sum slice, its carry, and the not-yet-consumed upper operand slices (skew pipeline). Lower sum slices are delayed so that all slices align at the output.
- Each stage has a valid bit that shifts with adv. When in_valid is low while adv is high, a bubble (valid=0) enters. Bubbles are not collapsed.
- When adv=0, every stage register, every valid bit and the outputs hold.
- ovf is computed from the MSBs of a and b carried along the pipeline and the final sum MSB.
- WIDTH % BLK != 0 or BLK < 1 is an elaboration-time error ($error/$fatal in a generate check).

## Timing
- Latency is exactly NSTG cycles from the input-transfer edge to out_valid=1 (4 cycles at default), assuming no stalls.
- Throughput is 1 result/cycle with out_ready held high.
- Reset (rst_n=0), asynchronously:
  - out_valid=0, sum=0, cout=0, ovf=0.
  - All stage valid bits and data registers cleared.
  - in_ready=1 while reset is held.
- Reset mid-operation discards all in-flight results. No partial result appears after rst_n rises. The first result appears NSTG cycles after the first post-reset transfer.
- Stall with out_valid=1 and out_ready=0: in_ready=0, and sum/cout/ovf remain stable until the transfer cycle.
- A simultaneous output transfer and input transfer in the same cycle is legal and loses no result.
- out_valid=1 while a bubble occupies stage NSTG-1: the output slot empties normally, and in_ready stays 1.
- Wrap-around: the sum is modulo 2^WIDTH, and the carry is reported only on cout.

## Structure
- Shared package csa_pkg: the WIDTH/BLK default constants and a function that computes NSTG and checks legality.
- Sub-module csa_block:
  - Parameter BLK; inputs x, y, csel; outputs s, co.
  - Purely combinational: two ripple adders (carry-in 0 and 1) plus a mux.
  - Instantiated NSTG times by a generate loop.
- The top level holds only the pipeline registers, the valid chain and the advance logic.

## Test plan
- Reset, then a=0x001F, b=0x000C, cin=0 -> after 4 cycles out_valid=1, sum=0x002B, cout=0, ovf=0.
- Back-to-back inputs on consecutive cycles, out_ready=1, in this order:
  - 0xC61F+0x018C+1
  - 0xFFFF+0x4000+1
  - 0x9249+0x9249+1

  Required on consecutive cycles: sum=0xC7AC cout=0 ovf=0; sum=0x4000 cout=1 ovf=0; sum=0x2493 cout=1 ovf=1.
- a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Then with WIDTH=32, BLK=8: a=0xFFFFFFFF, b=0, cin=1 -> sum=0, cout=1, latency 4.
- Stall: hold out_ready=0 for 5 cycles with 6 operations issued -> in_ready drops once full. Releasing out_ready yields all 6 results in order, none lost or duplicated, with sum stable during the stall.
- Assert rst_n low mid-stream with 3 operations in flight -> out_valid=0 and sum=0 immediately (asynchronously). No stale result appears after release.
- Random back-to-back traffic with random in_valid/out_ready for 10k cycles, compared against a behavioural a+b+cin model for {cout, sum} and ovf.
